// File: rtl/mux21_arb.sv
// Two-requester arbiter that owns a shared 2:1 mux path and registers the selected data.
// Alternates ownership under contention after MAX_HOLD consecutive granted cycles.
module mux21_arb #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             S,
    output logic [WIDTH-1:0] Y,
    output logic             VALID
);

    // state | meaning
    // IDLE  | nobody owns the path
    // OWN0  | requester 0 owns the path, D0 selected
    // OWN1  | requester 1 owns the path, D1 selected
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(MAX_HOLD - 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_last;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_last  <= 1'b1;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Ties go to whoever was not granted last.
                    if (REQ0 && (!REQ1 || r_last)) begin
                        r_state <= OWN0;
                        r_cnt   <= 4'd0;
                        r_last  <= 1'b0;
                    end else if (REQ1) begin
                        r_state <= OWN1;
                        r_cnt   <= 4'd0;
                        r_last  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (REQ0) begin
                        r_y     <= D0;
                        r_valid <= 1'b1;
                        if (REQ1 && (r_cnt == CNT_MAX)) begin
                            r_state <= OWN1;
                            r_cnt   <= 4'd0;
                            r_last  <= 1'b1;
                        end else if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else if (REQ1) begin
                        r_state <= OWN1;
                        r_cnt   <= 4'd0;
                        r_last  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                OWN1: begin
                    if (REQ1) begin
                        r_y     <= D1;
                        r_valid <= 1'b1;
                        if (REQ0 && (r_cnt == CNT_MAX)) begin
                            r_state <= OWN0;
                            r_cnt   <= 4'd0;
                            r_last  <= 1'b0;
                        end else if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else if (REQ0) begin
                        r_state <= OWN0;
                        r_cnt   <= 4'd0;
                        r_last  <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign GNT0  = (r_state == OWN0);
    assign GNT1  = (r_state == OWN1);
    assign S     = (r_state == OWN1);
    assign Y     = r_y;
    assign VALID = r_valid;

endmodule

// File: tb/tb_mux21_arb.sv
// Directed testbench for mux21_arb: reset, single grant, contention, saturation,
// direct handoff, mid-grant reset and idle hold.
module tb_mux21_arb;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ0 = 1'b0;
    logic       REQ1 = 1'b0;
    logic [7:0] D0 = 8'h00;
    logic [7:0] D1 = 8'h00;
    logic       GNT0, GNT1, S, VALID;
    logic [7:0] Y;

    int checks = 0;
    int errors = 0;

    mux21_arb #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1), .D0(D0), .D1(D1),
        .GNT0(GNT0), .GNT1(GNT1), .S(S), .Y(Y), .VALID(VALID)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Advance one rising edge, then settle so outputs can be sampled.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        REQ0  = 1'b0;
        REQ1  = 1'b0;
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        checks++;
        if ({GNT0, GNT1, S, VALID, Y} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got gnt0=%b gnt1=%b s=%b valid=%b y=%h, want all 0",
                     GNT0, GNT1, S, VALID, Y);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_single();
        REQ0 = 1'b1;
        D0   = 8'hA5;
        tick();
        checks++;
        if ({GNT0, GNT1, S, VALID, Y} !== {4'b1000, 8'h00}) begin
            errors++;
            $display("FAIL single_grant: got gnt0=%b gnt1=%b s=%b valid=%b y=%h, want 1 0 0 0 00",
                     GNT0, GNT1, S, VALID, Y);
        end
        tick();
        checks++;
        if ({GNT0, GNT1, S, VALID, Y} !== {4'b1001, 8'hA5}) begin
            errors++;
            $display("FAIL single_capture: got gnt0=%b gnt1=%b s=%b valid=%b y=%h, want 1 0 0 1 a5",
                     GNT0, GNT1, S, VALID, Y);
        end
        REQ0 = 1'b0;
        D0   = 8'h5A;
        tick();
        checks++;
        if ({GNT0, GNT1, S, VALID, Y} !== {4'b0000, 8'hA5}) begin
            errors++;
            $display("FAIL single_release: got gnt0=%b gnt1=%b s=%b valid=%b y=%h, want 0 0 0 0 a5",
                     GNT0, GNT1, S, VALID, Y);
        end
    endtask

    task automatic test_contention();
        logic       exp_g0;
        logic [7:0] exp_y;
        do_reset();
        D0   = 8'h10;
        D1   = 8'h20;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_g0 = (((k - 1) / 4) % 2) == 0;
            checks++;
            if ({GNT0, GNT1, S} !== {exp_g0, !exp_g0, !exp_g0}) begin
                errors++;
                $display("FAIL contention_gnt[%0d]: got gnt0=%b gnt1=%b s=%b, want %b %b %b",
                         k, GNT0, GNT1, S, exp_g0, !exp_g0, !exp_g0);
            end
            if (k >= 2) begin
                exp_y = ((((k - 2) / 4) % 2) == 0) ? 8'h10 : 8'h20;
                checks++;
                if ({VALID, Y} !== {1'b1, exp_y}) begin
                    errors++;
                    $display("FAIL contention_data[%0d]: got valid=%b y=%h, want 1 %h",
                             k, VALID, Y, exp_y);
                end
            end
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        REQ1 = 1'b1;
        D1   = 8'h33;
        D0   = 8'h99;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if ({GNT0, GNT1, S} !== 3'b011) begin
                errors++;
                $display("FAIL saturate_hold[%0d]: got gnt0=%b gnt1=%b s=%b, want 0 1 1",
                         k, GNT0, GNT1, S);
            end
        end
        REQ0 = 1'b1;
        D0   = 8'h44;
        tick();
        checks++;
        if ({GNT0, GNT1, S, VALID, Y} !== {4'b1001, 8'h33}) begin
            errors++;
            $display("FAIL saturate_switch: got gnt0=%b gnt1=%b s=%b valid=%b y=%h, want 1 0 0 1 33",
                     GNT0, GNT1, S, VALID, Y);
        end
        tick();
        checks++;
        if ({VALID, Y} !== {1'b1, 8'h44}) begin
            errors++;
            $display("FAIL saturate_newdata: got valid=%b y=%h, want 1 44", VALID, Y);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        REQ0 = 1'b1;
        D0   = 8'h11;
        tick();
        tick();
        checks++;
        if ({GNT0, VALID, Y} !== {2'b11, 8'h11}) begin
            errors++;
            $display("FAIL handoff_own0: got gnt0=%b valid=%b y=%h, want 1 1 11", GNT0, VALID, Y);
        end
        REQ0 = 1'b0;
        REQ1 = 1'b1;
        D0   = 8'hEE;
        D1   = 8'h22;
        tick();
        checks++;
        if ({GNT0, GNT1, S, VALID, Y} !== {4'b0110, 8'h11}) begin
            errors++;
            $display("FAIL handoff_switch: got gnt0=%b gnt1=%b s=%b valid=%b y=%h, want 0 1 1 0 11",
                     GNT0, GNT1, S, VALID, Y);
        end
        tick();
        checks++;
        if ({GNT1, VALID, Y} !== {2'b11, 8'h22}) begin
            errors++;
            $display("FAIL handoff_capture: got gnt1=%b valid=%b y=%h, want 1 1 22", GNT1, VALID, Y);
        end
    endtask

    task automatic test_reset_mid();
        D1    = 8'h55;
        RST_N = 1'b0;
        tick();
        checks++;
        if ({GNT0, GNT1, S, VALID, Y} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs: got gnt0=%b gnt1=%b s=%b valid=%b y=%h, want all 0",
                     GNT0, GNT1, S, VALID, Y);
        end
        RST_N = 1'b1;
        REQ0  = 1'b1;
        REQ1  = 1'b1;
        D0    = 8'h66;
        tick();
        checks++;
        if ({GNT0, GNT1, S, VALID} !== 4'b1000) begin
            errors++;
            $display("FAIL midreset_favour0: got gnt0=%b gnt1=%b s=%b valid=%b, want 1 0 0 0",
                     GNT0, GNT1, S, VALID);
        end
    endtask

    task automatic test_idle();
        tick();
        checks++;
        if ({VALID, Y} !== {1'b1, 8'h66}) begin
            errors++;
            $display("FAIL idle_precapture: got valid=%b y=%h, want 1 66", VALID, Y);
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        D0   = 8'hC3;
        D1   = 8'h3C;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if ({GNT0, GNT1, S, VALID, Y} !== {4'b0000, 8'h66}) begin
                errors++;
                $display("FAIL idle_hold[%0d]: got gnt0=%b gnt1=%b s=%b valid=%b y=%h, want 0 0 0 0 66",
                         k, GNT0, GNT1, S, VALID, Y);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux21_arb.md
MUX21_ARB -- requirements
Module: mux21_arb

Interface
REQ-001 Parameter: WIDTH, default 8, data width of both inputs and the output.
REQ-002 Parameter: MAX_HOLD, default 4, maximum consecutive granted cycles under contention; legal range 2..16.
REQ-003 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: RST_N  input  1  reset, synchronous, active-low.
REQ-005 Port: REQ0  input  1  requester 0 asks for the shared 2:1 mux path.
REQ-006 Port: REQ1  input  1  requester 1 asks for the shared 2:1 mux path.
REQ-007 Port: D0  input  WIDTH  requester 0 data.
REQ-008 Port: D1  input  WIDTH  requester 1 data.
REQ-009 Port: GNT0  output  1  requester 0 owns the path.
REQ-010 Port: GNT1  output  1  requester 1 owns the path.
REQ-011 Port: S  output  1  mux select in use; 1 selects D1.
REQ-012 Port: Y  output  WIDTH  registered mux output.
REQ-013 Port: VALID  output  1  Y holds data captured on the previous edge.

Function
REQ-014 States SHALL be IDLE, OWN0 and OWN1; GNT0 = (state==OWN0), GNT1 = (state==OWN1), S = (state==OWN1), all decoded from registers.
REQ-015 Internal LAST bit SHALL record the most recently granted requester and be updated on every entry to OWN0/OWN1.
REQ-016 IDLE: REQ0 only -> OWN0; REQ1 only -> OWN1; both -> OWN of requester != LAST; none -> stay.
REQ-017 OWNx, REQx low at the edge: other requester high -> OWNother, else -> IDLE.
REQ-018 OWNx, REQx high, CNT==MAX_HOLD-1, other requester high -> OWNother (preemption); OWN0->OWN1 and OWN1->OWN0 switch directly, with no IDLE cycle.
REQ-019 CNT (4 bits) SHALL clear on entry to any OWN state, increment on each edge that keeps OWNx with REQx high, and saturate at MAX_HOLD-1.
REQ-020 When saturated and the other requester is idle, the owner SHALL keep the grant indefinitely; the switch occurs on the first edge at which the other requester is high.
REQ-021 Capture: at each edge with state OWNx and REQx high, Y <= Dx and VALID <= 1; otherwise VALID <= 0 and Y holds its value.
REQ-022 Latency: REQ sampled at edge n -> GNT high after edge n -> Dx captured at edge n+1 -> Y/VALID valid after edge n+1.
REQ-023 The owner's data SHALL be captured on its final granted cycle, including the cycle ending in preemption.
REQ-024 Inputs sampled while a requester has no grant SHALL never reach Y.

Reset
REQ-025 At any edge with RST_N low, regardless of state: state=IDLE, CNT=0, LAST=1, Y=0, VALID=0; hence GNT0=GNT1=S=0.
REQ-026 Reset applied mid-grant SHALL abort the grant with no capture on that edge; after release, arbitration restarts from IDLE with requester 0 favoured.

Verification
REQ-027 Reset, then REQ0=1 only, D0=8'hA5 -> GNT0=1 after 1 edge; Y=8'hA5, VALID=1 after 2 edges; S=0 throughout.
REQ-028 After reset, REQ0=REQ1=1 at the same edge (MAX_HOLD=4) -> GNT0 for exactly 4 cycles, then GNT1 for 4 cycles, alternating; GNT0 and GNT1 never both high.
REQ-029 REQ1 alone held for 10 cycles, then REQ0 raised -> GNT1 stays for those 10 cycles (CNT saturated); GNT0 follows on the next edge; S goes 1->0.
REQ-030 OWN0 with D0=8'h11, REQ0 dropped while REQ1=1 with D1=8'h22 -> next cycle GNT1=1 with no idle gap; Y=8'h22 one edge later; no VALID for the edge where REQ0 was low.
REQ-031 RST_N low for 1 cycle during OWN1 with VALID=1 -> all outputs 0 after that edge; with both requests held afterwards, GNT0 wins first.
REQ-032 REQ0=REQ1=0 for 5 cycles -> state IDLE, VALID=0, Y held at its last captured value.
